// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and the bit-counter width helper.
package serial_add_pkg;

  // FSM state encodings (plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must hold 0..W without wrapping; one spare bit over clog2(W)
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
// This is the only arithmetic in the serial adder; it is reused every cycle.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p1;
  logic g1;
  logic g2;

  // Half adder 1 on the operand bits, half adder 2 folds in the carry
  always_comb begin
    p1 = a ^ b;
    g1 = a & b;
    s  = p1 ^ c;
    g2 = p1 & c;
    co = g1 | g2;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Adds two W-bit operands LSB first through a
// single full-adder cell, one bit per clock, with valid/ready handshakes on
// both sides. Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN,
// which adds a Sub input: B is stored inverted and the carry seeds to 1.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         Sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Sum,
  output logic         Cout
);

  localparam int unsigned CntW = cnt_width(W);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            c_q, c_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  // Shared full-adder datapath, fed from the operand LSBs and the carry flop
  serial_fa_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshakes decode from registered state only
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    Sum       = sum_q;
    Cout      = cout_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
`ifdef SERIAL_ADD_SUB_EN
          // Two's-complement subtract: A + ~B + 1
          if (Sub) begin
            b_d = ~B;
            c_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        // Enter at MSB so the first (LSB) result bit lands at bit 0 after W shifts
        sum_d = {fa_s, sum_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (W=8). Subtract vectors
// run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         sub_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef SERIAL_ADD_SUB_EN
    .Sub       (sub_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set, wait for the result and check latency and value.
  // Leaves the DUT in DONE (result visible) for the caller to release.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                        input logic exp_cout);
    int cycles;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    A        = a;
    B        = b;
    Cin      = cin;
    sub_s    = sub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cycles   = 0;
    while (!out_valid && cycles < 3 * W) begin
      step();
      cycles++;
    end
    check_eq({tag, "_latency"}, cycles, W);
    check_eq({tag, "_sum"}, {24'd0, Sum}, {24'd0, exp_sum});
    check_eq({tag, "_cout"}, {31'd0, Cout}, {31'd0, exp_cout});
  endtask

  // Release a finished result with out_ready and confirm return to IDLE
  task automatic release_op(input string tag);
    out_ready = 1'b1;
    step();
    check_eq({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    sub_s     = 1'b0;
    out_ready = 1'b1;

    // Reset then idle
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_sum", {24'd0, Sum}, 32'd0);
    check_eq("rst_cout", {31'd0, Cout}, 32'd0);

    // Basic add and carry chains with out_ready held high early
    run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0);
    release_op("add_3c_05");
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    release_op("add_ff_01");
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    release_op("add_ff_ff_c");

    // Backpressure: result must hold and new operands be ignored
    out_ready = 1'b0;
    run_op("bp", 8'h81, 8'h80, 1'b1, 1'b0, 8'h02, 1'b1);
    A        = 8'h55;
    B        = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_hold_sum", {24'd0, Sum}, 32'h02);
      check_eq("bp_hold_cout", {31'd0, Cout}, 32'd1);
    end
    in_valid = 1'b0;
    release_op("bp");

    // Reset mid-RUN once the counter has reached 3
    A        = 8'hAA;
    B        = 8'h33;
    Cin      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check_eq("mid_running", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_sum", {24'd0, Sum}, 32'd0);
    check_eq("mid_rst_cout", {31'd0, Cout}, 32'd0);
    run_op("after_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
    release_op("after_rst");

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    release_op("sub_05_07");
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
    release_op("sub_07_05");
    run_op("sub0_add", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0);
    release_op("sub0_add");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
